// File: rtl/spi_rx_pkg.sv
// Shared constants and FSM encoding for the SPI receiver.
package spi_rx_pkg;

    localparam int unsigned CLK_FREQ       = 50_000_000;
    localparam int unsigned DEFAULT_DATA_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer for a single asynchronous input bit.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_ff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ff <= '0;
        end else begin
            r_ff <= {r_ff[STAGES-2:0], d};
        end
    end

    assign q = r_ff[STAGES-1];

endmodule

// File: rtl/spi_rx.sv
// SPI mode-0 receiver: synchronizes scl/sda/cs, shifts bits MSB first and
// presents each completed word with valid/overrun handshake and frame error pulse.
module spi_rx
    import spi_rx_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              scl,
    input  logic              sda,
    input  logic              cs,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              overrun,
    output logic              frame_err
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic w_scl_sync;
    logic w_sda_sync;
    logic w_cs_sync;
    logic w_scl_rise;
    logic [DATA_W-1:0] w_shift_next;

    state_t            r_state;
    logic              r_scl_prev;
    logic [DATA_W-2:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_overrun;
    logic              r_frame_err;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_scl (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (scl),
        .q       (w_scl_sync)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sda (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sda),
        .q       (w_sda_sync)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (cs),
        .q       (w_cs_sync)
    );

    assign w_scl_rise   = w_scl_sync & ~r_scl_prev;
    // Only DATA_W-1 bits are stored; the incoming bit completes the word.
    assign w_shift_next = {r_shift, w_sda_sync};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_scl_prev  <= 1'b0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_scl_prev  <= w_scl_sync;
            r_frame_err <= 1'b0;

            if (rd_en && r_valid) begin
                r_valid <= 1'b0;
            end
            if (rd_en && r_overrun) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (!w_cs_sync) begin
                        r_state <= RECV;
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end
                end
                RECV: begin
                    if (w_cs_sync) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_shift <= '0;
                        if (r_cnt != '0) begin
                            r_frame_err <= 1'b1;
                        end
                    end else if (w_scl_rise) begin
                        r_shift <= w_shift_next[DATA_W-2:0];
                        if (r_cnt == LAST_BIT) begin
                            r_cnt   <= '0;
                            r_data  <= w_shift_next;
                            // Completion wins over a same-cycle read.
                            r_valid <= 1'b1;
                            if (r_valid && !rd_en) begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_out  = r_data;
    assign valid     = r_valid;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_rx.sv
// Directed self-checking bench for spi_rx (DATA_W=8, SYNC_STAGES=2, scl period 6 clk).
module tb_spi_rx;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl     = 1'b0;
    logic       sda     = 1'b0;
    logic       cs      = 1'b1;
    logic       rd_en   = 1'b0;
    logic [7:0] data_out;
    logic       valid;
    logic       overrun;
    logic       frame_err;

    int n_cmp  = 0;
    int n_err  = 0;
    int fe_cnt = 0;
    int fe0;

    spi_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl       (scl),
        .sda       (sda),
        .cs        (cs),
        .rd_en     (rd_en),
        .data_out  (data_out),
        .valid     (valid),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Counts cycles with frame_err high (sampled pre-update at each rising edge).
    always @(posedge clk) if (frame_err === 1'b1) fe_cnt++;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sda = b; scl = 1'b0; tick(3);
        scl = 1'b1; tick(3);
    endtask

    // mode 0: plain, 1: check valid latency on the last bit, 2: rd_en coincides with completion
    task automatic send_byte(input logic [7:0] d, input int mode);
        for (int i = 7; i >= 1; i--) send_bit(d[i]);
        sda = d[0]; scl = 1'b0; tick(3);
        scl = 1'b1;
        if (mode == 1) begin
            @(posedge clk); @(posedge clk); #1;
            n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL latency_early: valid=%b want 0", valid); end
            @(posedge clk); #1;
            n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL latency_valid: valid=%b want 1", valid); end
            @(negedge clk);
        end else if (mode == 2) begin
            @(posedge clk); @(posedge clk); @(negedge clk);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
        end else begin
            tick(3);
        end
        scl = 1'b0;
    endtask

    task automatic frame_start();
        cs = 1'b0; tick(4);
    endtask

    task automatic frame_end();
        scl = 1'b0; tick(4);
        cs = 1'b1; tick(4);
    endtask

    task automatic rd_pulse();
        rd_en = 1'b1; tick(1);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; tick(3);
        n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", data_out); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        reset_n = 1'b1; tick(2);
    endtask

    task automatic test_single();
        fe0 = fe_cnt;
        frame_start();
        send_byte(8'hA5, 1);
        n_cmp++; if (data_out !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h want a5", data_out); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL single_overrun: got %b want 0", overrun); end
        frame_end();
        n_cmp++; if (fe_cnt - fe0 !== 0) begin n_err++; $display("FAIL single_no_frame_err: got %0d want 0", fe_cnt - fe0); end
        rd_pulse();
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL single_read_clears: got %b want 0", valid); end
    endtask

    task automatic test_back_to_back();
        frame_start();
        send_byte(8'h3C, 1);
        n_cmp++; if (data_out !== 8'h3C) begin n_err++; $display("FAIL b2b_data0: got %h want 3c", data_out); end
        rd_pulse();
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL b2b_read0: got %b want 0", valid); end
        send_byte(8'hC3, 0);
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid1: got %b want 1", valid); end
        n_cmp++; if (data_out !== 8'hC3) begin n_err++; $display("FAIL b2b_data1: got %h want c3", data_out); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
        rd_pulse();
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL b2b_read1: got %b want 0", valid); end
        frame_end();
    endtask

    task automatic test_coincide();
        frame_start();
        send_byte(8'h66, 0);
        send_byte(8'h99, 2);
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL coincide_valid: got %b want 1", valid); end
        n_cmp++; if (data_out !== 8'h99) begin n_err++; $display("FAIL coincide_data: got %h want 99", data_out); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL coincide_overrun: got %b want 0", overrun); end
        rd_pulse();
        frame_end();
    endtask

    task automatic test_overrun();
        frame_start();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        frame_end();
        n_cmp++; if (data_out !== 8'h22) begin n_err++; $display("FAIL ovr_data: got %h want 22", data_out); end
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b want 1", valid); end
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        rd_pulse();
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL ovr_read_valid: got %b want 0", valid); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_read_clear: got %b want 0", overrun); end
    endtask

    task automatic test_frame_err();
        fe0 = fe_cnt;
        frame_start();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        scl = 1'b0; tick(2);
        cs = 1'b1; tick(6);
        n_cmp++; if (fe_cnt - fe0 !== 1) begin n_err++; $display("FAIL ferr_pulse: got %0d want 1", fe_cnt - fe0); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL ferr_no_valid: got %b want 0", valid); end
        n_cmp++; if (data_out !== 8'h22) begin n_err++; $display("FAIL ferr_data_kept: got %h want 22", data_out); end
        frame_start();
        send_byte(8'h81, 0);
        frame_end();
        n_cmp++; if (data_out !== 8'h81) begin n_err++; $display("FAIL ferr_next_data: got %h want 81", data_out); end
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL ferr_next_valid: got %b want 1", valid); end
        n_cmp++; if (fe_cnt - fe0 !== 1) begin n_err++; $display("FAIL ferr_single: got %0d want 1", fe_cnt - fe0); end
    endtask

    task automatic test_idle_ignore();
        fe0 = fe_cnt;
        cs = 1'b1;
        send_byte(8'h3C, 0);
        send_byte(8'hF0, 0);
        tick(4);
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL idle_valid: got %b want 1", valid); end
        n_cmp++; if (data_out !== 8'h81) begin n_err++; $display("FAIL idle_data: got %h want 81", data_out); end
        n_cmp++; if (fe_cnt - fe0 !== 0) begin n_err++; $display("FAIL idle_frame_err: got %0d want 0", fe_cnt - fe0); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL idle_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_reset_mid();
        fe0 = fe_cnt;
        frame_start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        reset_n = 1'b0; tick(1);
        n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rstmid_data: got %h want 00", data_out); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", valid); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rstmid_overrun: got %b want 0", overrun); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rstmid_frame_err: got %b want 0", frame_err); end
        cs = 1'b1; scl = 1'b0; tick(2);
        reset_n = 1'b1; tick(4);
        frame_start();
        send_byte(8'h5A, 0);
        frame_end();
        n_cmp++; if (data_out !== 8'h5A) begin n_err++; $display("FAIL rstmid_next_data: got %h want 5a", data_out); end
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL rstmid_next_valid: got %b want 1", valid); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rstmid_next_overrun: got %b want 0", overrun); end
        n_cmp++; if (fe_cnt - fe0 !== 0) begin n_err++; $display("FAIL rstmid_no_frame_err: got %0d want 0", fe_cnt - fe0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_coincide();
        test_overrun();
        test_frame_err();
        test_idle_ignore();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_rx.md
SPI_RX -- requirements
Module: spi_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8: bits per frame, MSB first.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flip-flop depth of the input synchronizers, minimum 2.
REQ-003 SHALL have port clk, input, 1: system clock; everything runs on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port scl, input, 1: serial clock from the SPI transmitter (CPOL=0, CPHA=0), asynchronous to clk.
REQ-006 SHALL have port sda, input, 1: serial data; MSB first; stable around the scl rising edge.
REQ-007 SHALL have port cs, input, 1: active-low frame enable.
REQ-008 SHALL have port rd_en, input, 1: consumer acknowledge; clears valid.
REQ-009 SHALL have port data_out, output, DATA_W: last completed byte.
REQ-010 SHALL have port valid, output, 1: level signal; high while data_out is unread.
REQ-011 SHALL have port overrun, output, 1: sticky flag; a byte completed while valid was still high.
REQ-012 SHALL have port frame_err, output, 1: one-cycle pulse when cs deasserts mid-byte.

Function
REQ-013 SHALL pass scl, sda and cs through separate SYNC_STAGES-deep synchronizers of equal depth before any use.
REQ-014 SHALL detect an scl rise when the synchronized scl is 1 and its registered previous value is 0.
REQ-015 SHALL use FSM states IDLE, RECV.
- IDLE -> RECV when synchronized cs = 0.
- RECV -> IDLE when synchronized cs = 1.
REQ-016 In RECV, on each scl rise, SHALL shift the synchronized sda into the LSB of the shift register and increment a bit counter of width $clog2(DATA_W).
REQ-017 On the rise that completes bit DATA_W, SHALL do all of the following on the same clk edge:
- load data_out with {shift[DATA_W-2:0], sda_sync};
- set valid = 1;
- reset the bit counter to 0.
RECV then continues with the next byte without needing a cs toggle.
REQ-018 Latency SHALL be SYNC_STAGES+1 clk edges from the raw scl rise of the last bit to valid = 1.
REQ-019 SHALL clear valid on the clk edge after rd_en = 1 is sampled; rd_en while valid = 0 SHALL have no effect.
REQ-020 If a byte completes while valid = 1 and rd_en = 0, SHALL:
- overwrite data_out with the new byte;
- keep valid = 1;
- set overrun = 1.
REQ-021 If completion and rd_en coincide, valid SHALL stay 1 with the new data, and overrun SHALL NOT set.
REQ-022 overrun SHALL clear only when rd_en = 1 is sampled while overrun = 1, or on reset.
REQ-023 When cs deasserts with bit counter ≠ 0, SHALL:
- discard the partial byte;
- pulse frame_err for exactly one cycle;
- leave data_out and valid unchanged.
REQ-024 When cs deasserts with bit counter = 0, SHALL NOT pulse frame_err.
REQ-025 SHALL ignore scl rises while in IDLE or while synchronized cs = 1.
REQ-026 SHALL clear the bit counter and shift register on every IDLE -> RECV transition.

Reset
REQ-027 While reset_n = 0, SHALL force the following:
- state = IDLE;
- data_out = 0, valid = 0, overrun = 0, frame_err = 0;
- shift register, bit counter and every synchronizer stage = 0.
REQ-028 Reset asserted mid-byte SHALL discard the partial byte with no valid and no frame_err.
REQ-029 After reset release, the first byte SHALL be received correctly from the next cs assertion.

Structure
REQ-030 The shared defines header SHALL hold CLK_FREQ, the default DATA_W and the FSM state encodings.
REQ-031 The synchronizer SHALL be a sub-module, sync_ff (parameter STAGES), instantiated three times.
REQ-032 The edge detector, FSM, shift register and output register SHALL live in spi_rx.

Verification
REQ-033 cs low, 0xA5 sent at scl period 6 clk -> data_out = 0xA5, valid = 1, 3 clk after the 8th raw scl rise; overrun = 0.
REQ-034 0x3C then 0xC3 back-to-back in one cs frame, rd_en pulsed after each -> two valid windows, data 0x3C then 0xC3, overrun = 0.
REQ-035 0x11 then 0x22 with no rd_en -> data_out = 0x22, valid = 1, overrun = 1; one rd_en -> valid = 0, overrun = 0.
REQ-036 cs deasserted after 5 bits of 0xFF, then a new frame with 0x81 -> one frame_err pulse, no valid for the aborted byte, data_out = 0x81.
REQ-037 Toggling scl and sda while cs = 1 -> valid, frame_err and data_out unchanged.
REQ-038 reset_n pulsed low after 4 bits, then 0x5A sent -> all outputs 0 during reset, then data_out = 0x5A with no frame_err.
